// File: rtl/dht11_frame_reader_pkg.sv
// Shared DHT11 definitions: FSM state encodings, protocol timing defaults and
// frame byte-lane offsets (the lane offsets are also used by the UART sequencer).
package dht11_frame_reader_pkg;

  // state | meaning
  // POWERUP sensor settle | START_LOW host pulse | WAIT_RESP..RESP_HIGH sensor ack
  // BIT_LOW/BIT_HIGH data bit | CHECK checksum | WAIT poll interval
  typedef enum logic [3:0] {
    S_POWERUP   = 4'd0,
    S_START_LOW = 4'd1,
    S_WAIT_RESP = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_WAIT      = 4'd8
  } state_t;

  localparam int unsigned DEF_CLK_FREQ      = 12_000_000;
  localparam int unsigned DEF_POWERUP_MS    = 1000;
  localparam int unsigned DEF_START_LOW_US  = 20000;
  localparam int unsigned DEF_POLL_MS       = 2000;
  localparam int unsigned DEF_BIT_THRESH_US = 48;
  localparam int unsigned DEF_TIMEOUT_US    = 200;

  localparam int unsigned US_CNT_W   = 21;
  localparam int unsigned FRAME_BITS = 40;

  localparam int unsigned LANE_HUM_INT  = 32;
  localparam int unsigned LANE_HUM_DEC  = 24;
  localparam int unsigned LANE_TEMP_INT = 16;
  localparam int unsigned LANE_TEMP_DEC = 8;
  localparam int unsigned LANE_CKS      = 0;

  function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
    return f[LANE_HUM_INT +: 8] + f[LANE_HUM_DEC +: 8] +
           f[LANE_TEMP_INT +: 8] + f[LANE_TEMP_DEC +: 8];
  endfunction

endpackage

// File: rtl/dht11_frame_reader_us_timer.sv
// Microsecond timebase: clock prescaler plus a saturating elapsed-us counter.
// A clear restarts the count with the clearing cycle already counted as elapsed.
module dht11_frame_reader_us_timer #(
  parameter int unsigned DIV   = 12,
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  output logic [CNT_W-1:0] us_cnt_o
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRESC_START = PW'((DIV > 1) ? 1 : 0);
  localparam logic [CNT_W-1:0] CNT_START   = CNT_W'((DIV > 1) ? 0 : 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if (clr_i) begin
      presc_d = PRESC_START;
      cnt_d   = CNT_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign us_cnt_o = cnt_q;

endmodule

// File: rtl/dht11_frame_reader.sv
// DHT11 single-wire frame reader: periodic start pulse, response/bit timing,
// checksum verification and last-good-frame output register.
module dht11_frame_reader
  import dht11_frame_reader_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
  parameter int unsigned POWERUP_MS    = DEF_POWERUP_MS,
  parameter int unsigned START_LOW_US  = DEF_START_LOW_US,
  parameter int unsigned POLL_MS       = DEF_POLL_MS,
  parameter int unsigned BIT_THRESH_US = DEF_BIT_THRESH_US,
  parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire         dht_data,
  output logic        data_valid,
  output logic [31:0] sensor_data,
  output logic        new_frame,
  output logic        checksum_err,
  output logic        timeout_err
);

  localparam int unsigned US_DIV = CLK_FREQ / 1_000_000;
  localparam logic [US_CNT_W-1:0] POWERUP_US = US_CNT_W'(POWERUP_MS * 1000);
  localparam logic [US_CNT_W-1:0] POLL_US    = US_CNT_W'(POLL_MS * 1000);
  localparam logic [US_CNT_W-1:0] START_US   = US_CNT_W'(START_LOW_US);
  localparam logic [US_CNT_W-1:0] THRESH_US  = US_CNT_W'(BIT_THRESH_US);
  localparam logic [US_CNT_W-1:0] TO_US      = US_CNT_W'(TIMEOUT_US);
  localparam logic [5:0]          LAST_BIT   = 6'(FRAME_BITS - 1);

  state_t                state_q, state_d;
  logic [US_CNT_W-1:0]   us_cnt;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  fall, rise, timed_out;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [31:0]           sensor_data_q, sensor_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  new_frame_q, new_frame_d;
  logic                  checksum_err_q, checksum_err_d;
  logic                  timeout_err_q, timeout_err_d;

  // Open-drain: reset forces S_POWERUP, so the line is released asynchronously.
  assign dht_data = (state_q == S_START_LOW) ? 1'b0 : 1'bz;

  dht11_frame_reader_us_timer #(
    .DIV   (US_DIV),
    .CNT_W (US_CNT_W)
  ) u_us_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (state_d != state_q),
    .us_cnt_o (us_cnt)
  );

  assign fall      = prev_q & ~sync2_q;
  assign rise      = ~prev_q & sync2_q;
  assign timed_out = (us_cnt >= TO_US);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    sensor_data_d  = sensor_data_q;
    data_valid_d   = data_valid_q;
    new_frame_d    = 1'b0;
    checksum_err_d = 1'b0;
    timeout_err_d  = 1'b0;
    case (state_q)
      S_POWERUP:   if (us_cnt >= POWERUP_US) state_d = S_START_LOW;
      S_START_LOW: if (us_cnt >= START_US) state_d = S_WAIT_RESP;
      S_WAIT_RESP: if (fall) state_d = S_RESP_LOW;
                   else if (timed_out) timeout_err_d = 1'b1;
      S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH;
                   else if (timed_out) timeout_err_d = 1'b1;
      S_RESP_HIGH: if (fall) begin
                     state_d   = S_BIT_LOW;
                     bit_cnt_d = '0;
                   end else if (timed_out) timeout_err_d = 1'b1;
      S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;
                   else if (timed_out) timeout_err_d = 1'b1;
      S_BIT_HIGH:  if (fall) begin
                     shreg_d = {shreg_q[FRAME_BITS-2:0], (us_cnt > THRESH_US)};
                     if (bit_cnt_q == LAST_BIT) begin
                       state_d = S_CHECK;
                     end else begin
                       bit_cnt_d = bit_cnt_q + 1'b1;
                       state_d   = S_BIT_LOW;
                     end
                   end else if (timed_out) timeout_err_d = 1'b1;
      S_CHECK: begin
        state_d = S_WAIT;
        if (frame_sum(shreg_q) == shreg_q[LANE_CKS +: 8]) begin
          sensor_data_d = shreg_q[FRAME_BITS-1:8];
          data_valid_d  = 1'b1;
          new_frame_d   = 1'b1;
        end else begin
          checksum_err_d = 1'b1;
        end
      end
      S_WAIT:      if (us_cnt >= POLL_US) state_d = S_START_LOW;
      default:     state_d = S_POWERUP;
    endcase
    if (timeout_err_d) begin
      shreg_d = '0;
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_POWERUP;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      prev_q         <= 1'b1;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      sensor_data_q  <= '0;
      data_valid_q   <= 1'b0;
      new_frame_q    <= 1'b0;
      checksum_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= dht_data;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      sensor_data_q  <= sensor_data_d;
      data_valid_q   <= data_valid_d;
      new_frame_q    <= new_frame_d;
      checksum_err_q <= checksum_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign data_valid   = data_valid_q;
  assign sensor_data  = sensor_data_q;
  assign new_frame    = new_frame_q;
  assign checksum_err = checksum_err_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed bench for dht11_frame_reader with a DHT11 sensor model on a pulled-up line.
`timescale 1ns/1ps
module tb_dht11_frame_reader;

  logic        clk;
  logic        reset_n;
  logic        bfm_low;
  wire         dht_data;
  logic        data_valid;
  logic [31:0] sensor_data;
  logic        new_frame;
  logic        checksum_err;
  logic        timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_new, n_cks, n_to;

  pullup (dht_data);
  assign dht_data = bfm_low ? 1'b0 : 1'bz;

  // 2 MHz clock: 2 cycles per us, short ms figures keep the run small.
  dht11_frame_reader #(
    .CLK_FREQ      (2_000_000),
    .POWERUP_MS    (1),
    .START_LOW_US  (100),
    .POLL_MS       (1),
    .BIT_THRESH_US (48),
    .TIMEOUT_US    (200)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dht_data     (dht_data),
    .data_valid   (data_valid),
    .sensor_data  (sensor_data),
    .new_frame    (new_frame),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #250 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (new_frame === 1'b1) n_new++;
    if (checksum_err === 1'b1) n_cks++;
    if (timeout_err === 1'b1) n_to++;
  endtask

  task automatic clr_cnt();
    n_new = 0; n_cks = 0; n_to = 0;
  endtask

  task automatic wait_us(input int n);
    repeat (n * 2) tick();
  endtask

  task automatic wait_line(input logic lvl, input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      if (dht_data === lvl) return;
    end
    cyc = -1;
  endtask

  // Sensor answer after host release; thresh forces bit highs 26/47/49/70 on bits 0..3.
  task automatic send_frame(input logic [39:0] f, input int nbits, input bit thresh);
    int h;
    wait_us(30);
    bfm_low = 1'b1; wait_us(80);
    bfm_low = 1'b0; wait_us(80);
    for (int i = 0; i < nbits; i++) begin
      bfm_low = 1'b1; wait_us(30);
      bfm_low = 1'b0;
      h = f[39-i] ? 70 : 26;
      if (thresh && i == 1) h = 47;
      if (thresh && i == 2) h = 49;
      wait_us(h);
    end
    if (nbits == 40) begin
      bfm_low = 1'b1; wait_us(30);
      bfm_low = 1'b0;
    end
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    bfm_low = 1'b0;
    clr_cnt();
    repeat (4) @(negedge clk);
    chk("rst_valid", 40'(data_valid), 40'h0);
    chk("rst_data", 40'(sensor_data), 40'h0);
    chk("rst_new", 40'(new_frame), 40'h0);
    chk("rst_cks", 40'(checksum_err), 40'h0);
    chk("rst_to", 40'(timeout_err), 40'h0);
    chk("rst_line", 40'(dht_data), 40'h1);
    reset_n = 1'b1;

    wait_line(1'b0, 6000, c);
    chk_rng("powerup_cyc", c, 1995, 2005);
    wait_line(1'b1, 1000, c);
    chk_rng("start_low_cyc", c, 199, 201);

    clr_cnt();
    send_frame(40'h37_00_19_00_50, 40, 1'b0);
    repeat (20) tick();
    chk("good_new", 40'(n_new), 40'd1);
    chk("good_cks", 40'(n_cks), 40'd0);
    chk("good_to", 40'(n_to), 40'd0);
    chk("good_data", 40'(sensor_data), 40'h37001900);
    chk("good_valid", 40'(data_valid), 40'h1);

    wait_line(1'b0, 6000, c);
    chk_rng("poll_retry1", c, 1800, 2000);
    wait_line(1'b1, 1000, c);
    clr_cnt();
    send_frame(40'h37_00_19_00_51, 40, 1'b0);
    repeat (20) tick();
    chk("bad_cks", 40'(n_cks), 40'd1);
    chk("bad_new", 40'(n_new), 40'd0);
    chk("bad_to", 40'(n_to), 40'd0);
    chk("bad_data", 40'(sensor_data), 40'h37001900);
    chk("bad_valid", 40'(data_valid), 40'h1);

    wait_line(1'b0, 6000, c);
    chk_rng("poll_retry2", c, 1800, 2000);
    wait_line(1'b1, 1000, c);
    clr_cnt();
    c = 0;
    while (c < 1000 && timeout_err !== 1'b1) begin
      tick();
      c++;
    end
    chk_rng("silent_to_cyc", c, 398, 402);
    chk("silent_line", 40'(dht_data), 40'h1);
    wait_line(1'b0, 6000, c);
    chk_rng("silent_restart", c, 1998, 2002);
    chk("silent_to_cnt", 40'(n_to), 40'd1);
    chk("silent_others", 40'(n_new + n_cks), 40'd0);
    chk("silent_data", 40'(sensor_data), 40'h37001900);

    wait_line(1'b1, 1000, c);
    clr_cnt();
    send_frame(40'h3F_C0_00_01_00, 40, 1'b1);
    repeat (20) tick();
    chk("thr_new", 40'(n_new), 40'd1);
    chk("thr_cks", 40'(n_cks), 40'd0);
    chk("thr_data", 40'(sensor_data), 40'h3FC00001);

    wait_line(1'b0, 6000, c);
    wait_line(1'b1, 1000, c);
    clr_cnt();
    send_frame(40'h37_00_19_00_50, 20, 1'b0);
    repeat (600) tick();
    chk("part_to", 40'(n_to), 40'd1);
    chk("part_new", 40'(n_new + n_cks), 40'd0);
    chk("part_data", 40'(sensor_data), 40'h3FC00001);

    wait_line(1'b0, 6000, c);
    wait_line(1'b1, 1000, c);
    send_frame(40'h37_00_19_00_50, 10, 1'b0);
    chk("midbit_pre_valid", 40'(data_valid), 40'h1);
    reset_n = 1'b0;
    #1;
    chk("midbit_line", 40'(dht_data), 40'h1);
    chk("midbit_valid", 40'(data_valid), 40'h0);
    chk("midbit_data", 40'(sensor_data), 40'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_line(1'b0, 6000, c);
    chk_rng("midbit_powerup", c, 1995, 2005);

    repeat (20) tick();
    chk("startlow_pre_line", 40'(dht_data), 40'h0);
    reset_n = 1'b0;
    #1;
    chk("startlow_line", 40'(dht_data), 40'h1);
    chk("startlow_outs", 40'({data_valid, new_frame, checksum_err, timeout_err}), 40'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_line(1'b0, 6000, c);
    chk_rng("startlow_powerup", c, 1995, 2005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
